ex_div: RTL and testbench
=========================

// Module: ex_div
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU, in the EX stage downstream of the ID/EX register.
//  Consumes ex_reg1_data/ex_reg2_data and returns {remainder, quotient} for the HI/LO write.
//  Holds stallreq_div while busy; ctrl uses it to freeze stall[2:0] and hold the ID/EX register.
// PARAMETERS
//  WIDTH   32   operand width; quotient and remainder are each WIDTH bits
//  CNT_W   6    iteration counter width; must be >= clog2(WIDTH+1)
// PORTS
//  clk           in   1        clock, rising edge
//  reset_n       in   1        asynchronous reset, active-low
//  start         in   1        divide request; held high by EX until ready
//  signed_div    in   1        1 = DIV (two's complement), 0 = DIVU
//  annul         in   1        cancel in-flight divide (flush/exception)
//  opdata1       in   WIDTH    dividend
//  opdata2       in   WIDTH    divisor
//  result        out  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}, registered
//  ready         out  1        result valid, registered
//  stallreq_div  out  1        combinational: start & ~ready
// BEHAVIOUR
//  Reset: state=IDLE, result=0, ready=0, cnt=0, work regs=0.
//  States:
//   IDLE   -- start & ~annul & opdata2==0 -> BYZERO; start & ~annul -> ON (capture |op1|,|op2|, cnt=0).
//   BYZERO -- one cycle; -> END with result=0.
//   ON     -- one restoring step per cycle: shift partial remainder left 1, subtract divisor,
//             keep on no borrow, shift quotient bit in; cnt++.
//             At cnt==WIDTH -> END: apply signs, register result.
//             annul -> IDLE, result=0.
//   END    -- ready=1; stays while start=1; start=0 -> IDLE (ready=0, result held).
//  Operand capture: at the start edge only; opdata changes during ON are ignored.
//  Latency: start sampled at edge k -> ready high after edge k+WIDTH+1.
//   Divide-by-zero: ready after edge k+2.
//  Signs (signed_div=1):
//   quotient negated iff op1[W-1]^op2[W-1];
//   remainder takes the dividend's sign; |r| < |op2|.
//   MIN/-1 wraps: quotient=0x80000000, remainder=0. No overflow flag.
//  Divisor zero: quotient=0, remainder=0, both modes.
//  annul in IDLE/END: forces IDLE, ready=0 next cycle. annul & start together: no new divide.
//  Reset mid-divide: IDLE immediately, all outputs 0.
// CONFIGURATION
//  DIV_EARLY_OUT_EN:
//   defined   -- in IDLE, if |op1| < |op2| (op2!=0), -> END next edge with quotient=0 and
//                remainder=op1 (unsigned: op1 unchanged; signed: original signed op1).
//                Latency 2 edges.
//   undefined -- always full WIDTH iterations; results identical, only latency differs.
// STRUCTURE
//  Shared package muldiv_pkg: DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END 2-bit encodings;
//   EXE_DIV_OP / EXE_DIVU_OP aluop codes; ZERO_WORD.
//  Sub-module div_step: combinational single restoring iteration,
//   (rem_in, quo_in, divisor) -> (rem_out, quo_out).
//  ex_div owns FSM, counter, sign fix-up.
// TESTING
//  1. DIVU 100/7, start held -> ready after edge k+33; result={32'd2, 32'd14}; stallreq_div=1 until then.
//  2. DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
//     DIV 7/-2 -> quotient -3, remainder 1.
//  3. DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
//     DIVU same operands -> quotient 0, remainder 0x80000000.
//  4. Divisor 0, any dividend -> ready after edge k+2, result=0, both modes.
//  5. annul at cnt=10 -> next cycle IDLE, ready=0, result=0.
//     Restart 9/3 -> quotient 3, remainder 0 at normal latency.
//  6. DIVU 5/9 -> result={32'd5, 32'd0}.
//     DIV_EARLY_OUT_EN defined: ready after edge k+2. Undefined: after edge k+33.
//     Also: reset_n low mid-ON -> outputs 0 asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared multiply/divide definitions: divider FSM encodings, EX-stage aluop codes and word constants.
package muldiv_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic [7:0]  EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0]  EXE_DIVU_OP = 8'b0001_1011;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  // True for the two aluops that route through the iterative divider.
  function automatic logic is_div_op(input logic [7:0] aluop);
    return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring division iteration: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           borrow;

  // The shifted remainder can reach 2*divisor-1, so the trial subtract needs one extra bit.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign borrow  = diff[WIDTH];

  assign rem_out = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/ex_div.sv
// EX-stage iterative radix-2 restoring divider for DIV/DIVU, returning {remainder, quotient}.
// Build option DIV_EARLY_OUT_EN: finish in two edges when |dividend| < |divisor|.
module ex_div
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq_div
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state;
  div_state_e       next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] divisor_q;
  logic             neg_quo;
  logic             neg_rem;

  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] fix_rem;
  logic [WIDTH-1:0] fix_quo;
  logic             div_by_zero;
  logic             early_out;

  assign abs1        = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2        = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  assign div_by_zero = (opdata2 == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early_out = !div_by_zero && (abs1 < abs2);
`else
  assign early_out = 1'b0;
`endif

  // Signs are applied to the final step's outputs so the result registers on the END transition.
  assign fix_quo = neg_quo ? -step_quo : step_quo;
  assign fix_rem = neg_rem ? -step_rem : step_rem;

  assign stallreq_div = start & ~ready;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (rem_q),
    .quo_in (quo_q),
    .divisor(divisor_q),
    .rem_out(step_rem),
    .quo_out(step_quo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= DIV_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // BYZERO also serves the early-out path; both just publish the preloaded work registers.
  always_comb begin
    next_state = state;
    unique case (state)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (div_by_zero || early_out) begin
            next_state = DIV_BYZERO;
          end else begin
            next_state = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        next_state = annul ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        if (annul) begin
          next_state = DIV_IDLE;
        end else if (cnt == LAST_CNT) begin
          next_state = DIV_END;
        end
      end
      DIV_END: begin
        if (annul || !start) begin
          next_state = DIV_IDLE;
        end
      end
      default: next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result    <= '0;
      ready     <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (next_state != DIV_IDLE) begin
            cnt       <= '0;
            divisor_q <= abs2;
            neg_quo   <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            neg_rem   <= signed_div & opdata1[WIDTH-1];
            if (next_state == DIV_ON) begin
              rem_q <= '0;
              quo_q <= abs1;
            end else begin
              rem_q <= early_out ? opdata1 : '0;
              quo_q <= '0;
            end
          end
        end
        DIV_BYZERO: begin
          if (next_state == DIV_END) begin
            result <= {rem_q, quo_q};
          end
        end
        DIV_ON: begin
          if (annul) begin
            result <= '0;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              result <= {fix_rem, fix_quo};
            end
          end
        end
        default: begin
        end
      endcase
      // Ready rises one edge after reaching END and drops on the edge that leaves it.
      ready <= (state == DIV_END) && (next_state == DIV_END);
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized divides against an
// arithmetic reference model; honours DIV_EARLY_OUT_EN for the expected latency.
`timescale 1ns/1ps
module tb_ex_div;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           signed_div = 1'b0;
  logic           annul = 1'b0;
  logic [W-1:0]   opdata1 = '0;
  logic [W-1:0]   opdata2 = '0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stallreq_div;

  int errors = 0;
  int checks = 0;

  // Model state: 0 idle, 1 divide running, 2 ready seen and leaving END, 3 annul pending
  int             phase = 0;
  int             edge_cnt = 0;
  int             exp_lat = 0;
  logic [2*W-1:0] exp_res = '0;

  ex_div #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .signed_div  (signed_div),
    .annul       (annul),
    .opdata1     (opdata1),
    .opdata2     (opdata2),
    .result      (result),
    .ready       (ready),
    .stallreq_div(stallreq_div)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] absOf(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  // Truncating 64-bit division gives the architectural quotient/remainder, including MIN/-1.
  function automatic logic [2*W-1:0] modelDiv(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int modelLat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    if (b == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
    if (absOf(a, sgn) < absOf(b, sgn)) return 2;
`endif
    return W + 1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    if (phase == 1) begin
      edge_cnt++;
    end else if (phase == 2) begin
      phase = 0;
    end else if (phase == 3) begin
      phase = 0;
      exp_res = '0;
    end
  end

  // Single compare process: every falling edge checks ready, stall and (when meaningful) result.
  always @(negedge clk) begin : compare
    bit exp_ready;
    exp_ready = ((phase == 1) && (edge_cnt >= exp_lat)) || (phase == 2);
    checkOutput("ready", {63'b0, ready}, {63'b0, exp_ready});
    checkOutput("stallreq_div", {63'b0, stallreq_div}, {63'b0, start & ~exp_ready});
    if (exp_ready || phase == 0) begin
      checkOutput("result", result, exp_res);
    end
  end

  // end_mode 0 drops start once ready; 1 raises annul with start still held.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                               input int end_mode);
    @(posedge clk);
    #2;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    exp_res    = modelDiv(a, b, sgn);
    exp_lat    = modelLat(a, b, sgn);
    edge_cnt   = -1;
    phase      = 1;
    repeat (exp_lat + 2) begin
      @(posedge clk);
      #2;
      opdata1 = $urandom;
      opdata2 = $urandom;
    end
    if (end_mode == 0) begin
      start = 1'b0;
      phase = 2;
    end else begin
      annul = 1'b1;
      phase = 2;
      repeat (3) @(posedge clk);
      #2;
      start = 1'b0;
      annul = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic annulDivide(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                             input int at_cnt);
    @(posedge clk);
    #2;
    opdata1    = a;
    opdata2    = b;
    signed_div = sgn;
    start      = 1'b1;
    exp_res    = modelDiv(a, b, sgn);
    exp_lat    = modelLat(a, b, sgn);
    edge_cnt   = -1;
    phase      = 1;
    repeat (at_cnt + 1) @(posedge clk);
    #2;
    annul = 1'b1;
    start = 1'b0;
    phase = 3;
    @(posedge clk);
    #2;
    annul = 1'b0;
  endtask

  task automatic resetMidDivide(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #2;
    opdata1    = a;
    opdata2    = b;
    signed_div = 1'b0;
    start      = 1'b1;
    exp_res    = modelDiv(a, b, 1'b0);
    exp_lat    = modelLat(a, b, 1'b0);
    edge_cnt   = -1;
    phase      = 1;
    repeat (6) @(posedge clk);
    #3;
    reset_n = 1'b0;
    start   = 1'b0;
    phase   = 0;
    exp_res = '0;
    #1;
    checkOutput("reset_mid_result", result, 64'h0);
    checkOutput("reset_mid_ready", {63'b0, ready}, 64'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_result", result, 64'h0);
    reset_n = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b0, 0);
    checkOutput("divu_100_7", result, {32'd2, 32'd14});

    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    checkOutput("div_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 1);
    checkOutput("div_7_m2", result, {32'd1, 32'hFFFF_FFFD});

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    checkOutput("div_min_m1", result, {32'h0, 32'h8000_0000});
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    checkOutput("divu_min_m1", result, {32'h8000_0000, 32'h0});

    applyStimulus(32'h1234_5678, 32'h0, 1'b0, 0);
    checkOutput("divu_by_zero", result, 64'h0);
    applyStimulus(32'hDEAD_BEEF, 32'h0, 1'b1, 0);
    checkOutput("div_by_zero", result, 64'h0);

    annulDivide(32'd1000, 32'd3, 1'b0, 10);
    checkOutput("annul_result", result, 64'h0);
    checkOutput("annul_ready", {63'b0, ready}, 64'h0);
    applyStimulus(32'd9, 32'd3, 1'b1, 0);
    checkOutput("div_9_3", result, {32'd0, 32'd3});

    resetMidDivide(32'd1000, 32'd7);

    applyStimulus(32'd5, 32'd9, 1'b0, 0);
    checkOutput("divu_5_9", result, {32'd5, 32'd0});

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      int           kind;
      kind = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      s    = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 50);
        end
        2: b = '0;
        3: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        4: b = $urandom_range(1, 15);
        5: begin
          a = $urandom_range(0, 100);
          b = $urandom_range(101, 100000);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: begin
        end
      endcase
      applyStimulus(a, b, s, $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
